counter_sequencer: RTL and testbench



---
 rtl/counter_seq_pkg.sv | 13 +
 rtl/step_counter.sv | 21 ++
 rtl/counter_sequencer.sv | 166 ++++++++++++++++
 tb/tb_counter_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared encodings for the counter sequencer: FSM states and mode constants.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_UP = 2'd1,
    RUN_DN = 2'd2
  } state_t;

  localparam logic MODE_SWEEP    = 1'b0;
  localparam logic MODE_PINGPONG = 1'b1;

endpackage

// File: rtl/step_counter.sv
// WIDTH-bit up/down counter with synchronous load; sole storage for count.
module step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  // Load wins over stepping; stepping wraps modulo 2^WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
  end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer driving step_counter through a single sweep or a ping-pong
// between latched limits. Define COUNTER_SEQ_PRESCALE_EN to build the
// prescaler; otherwise the counter steps every cycle and PRESCALE is ignored.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int REP_W    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [REP_W-1:0] repeats,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             up,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic               mode_q;
  logic [REP_W-1:0]   rem_q, rem_d;
  logic               up_d, busy_d, done_d, err_d;
  logic               latch, ld, en, dir, tick;

`ifdef COUNTER_SEQ_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] psc;

  assign tick = (psc == PW'(PRESCALE - 1));

  // Prescaler restarts on an accepted start and free-runs while sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                psc <= '0;
    else if (latch)           psc <= '0;
    else if (state_q != IDLE) psc <= tick ? '0 : psc + PW'(1);
  end
`else
  localparam int unused_prescale = PRESCALE;
  assign tick = 1'b1;
`endif

  step_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .load_val (lo),
    .en       (en),
    .up       (dir),
    .count    (count)
  );

  // State, status flags and latched command fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      up      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= MODE_SWEEP;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      up      <= up_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      if (latch) begin
        lo_q   <= lo;
        hi_q   <= hi;
        mode_q <= mode;
        rem_q  <= (repeats == '0) ? REP_W'(1) : repeats;
      end else begin
        rem_q  <= rem_d;
      end
    end
  end

  // Next state and counter control; abort beats any tick in a run state.
  always_comb begin
    state_d = state_q;
    up_d    = up;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rem_d   = rem_q;
    latch   = 1'b0;
    ld      = 1'b0;
    en      = 1'b0;
    dir     = up;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (lo <= hi) begin
            latch   = 1'b1;
            ld      = 1'b1;
            up_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = RUN_UP;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      RUN_UP: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (tick) begin
          if (count < hi_q) begin
            en  = 1'b1;
            dir = 1'b1;
          end else if (mode_q == MODE_SWEEP || lo_q == hi_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Turn around at hi without dwelling there.
            state_d = RUN_DN;
            up_d    = 1'b0;
            en      = 1'b1;
            dir     = 1'b0;
          end
        end
      end
      RUN_DN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (tick) begin
          if (count > lo_q) begin
            en  = 1'b1;
            dir = 1'b0;
          end else begin
            rem_d = rem_q - REP_W'(1);
            if (rem_d == '0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = RUN_UP;
              up_d    = 1'b1;
              en      = 1'b1;
              dir     = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: reset, sweep, ping-pong, errors,
// abort, lo=hi and prescaled stepping on a second instance.
module tb_counter_sequencer;

`ifdef COUNTER_SEQ_PRESCALE_EN
  localparam int EP = 3;
`else
  localparam int EP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, start3 = 1'b0, mode = 1'b0, abort = 1'b0, abort3 = 1'b0;
  logic [3:0] lo = '0, hi = '0, repeats = '0;
  logic [3:0] count, count3;
  logic       up, busy, done, err, up3, busy3, done3, err3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(4), .REP_W(4), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .lo(lo), .hi(hi),
    .repeats(repeats), .abort(abort), .count(count), .up(up), .busy(busy),
    .done(done), .err(err)
  );

  counter_sequencer #(.WIDTH(4), .REP_W(4), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .mode(mode), .lo(lo), .hi(hi),
    .repeats(repeats), .abort(abort3), .count(count3), .up(up3), .busy(busy3),
    .done(done3), .err(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] pp_cnt [8] = '{4'd2, 4'd3, 4'd2, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1};
  logic       pp_up  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    // Reset state
    cyc(); cyc();
    check("rst_count", count, 0);
    check("rst_up", up, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    cyc();

    // Single sweep 2..5
    start = 1; mode = 0; lo = 2; hi = 5; repeats = 0;
    cyc(); start = 0;
    check("sw_load", count, 2);
    check("sw_busy", busy, 1);
    check("sw_up", up, 1);
    for (int i = 3; i <= 5; i++) begin
      cyc();
      check("sw_step", count, i);
      check("sw_nodone", done, 0);
    end
    // Completion edge; queue a lo=hi ping-pong start while done is high
    cyc();
    check("sw_done", done, 1);
    check("sw_busy_fall", busy, 0);
    check("sw_hold", count, 5);
    start = 1; mode = 1; lo = 4; hi = 4;
    cyc(); start = 0;
    check("eq_load", count, 4);
    check("eq_busy", busy, 1);
    check("eq_done_clear", done, 0);
    cyc();
    check("eq_done", done, 1);
    check("eq_busy_fall", busy, 0);
    check("eq_count", count, 4);
    cyc();
    check("eq_done_pulse", done, 0);

    // Ping-pong 1..3, repeats=2, with an ignored start mid-run
    start = 1; mode = 1; lo = 1; hi = 3; repeats = 2;
    cyc(); start = 0; lo = 0; hi = 9;
    check("pp_load", count, 1);
    for (int i = 0; i < 8; i++) begin
      start = (i == 2);
      cyc();
      check("pp_count", count, pp_cnt[i]);
      check("pp_up", up, pp_up[i]);
      check("pp_busy", busy, 1);
    end
    start = 0;
    cyc();
    check("pp_done", done, 1);
    check("pp_busy_fall", busy, 0);
    check("pp_hold", count, 1);

    // Rejected start lo>hi
    cyc();
    start = 1; lo = 7; hi = 3;
    cyc(); start = 0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_count", count, 1);
    cyc();
    check("err_clear", err, 0);
    check("err_count2", count, 1);

    // Abort in IDLE ignored, then abort on final limit tick
    abort = 1;
    cyc(); abort = 0;
    check("idle_abort", busy, 0);
    start = 1; mode = 0; lo = 0; hi = 2;
    cyc(); start = 0;
    cyc(); cyc();
    check("ab_at_hi", count, 2);
    abort = 1;
    cyc(); abort = 0;
    check("ab_busy", busy, 0);
    check("ab_nodone", done, 0);
    check("ab_count", count, 2);
    cyc();
    check("ab_nodone2", done, 0);
    check("ab_frozen", count, 2);

    // Reset mid-sweep 2..9
    start = 1; lo = 2; hi = 9;
    cyc(); start = 0;
    cyc(); cyc();
    check("mid_count", count, 4);
    reset = 1;
    #1;
    check("mr_count", count, 0);
    check("mr_busy", busy, 0);
    check("mr_up", up, 1);
    check("mr_done", done, 0);
    cyc();
    reset = 0;
    cyc();
    check("mr_nodone", done, 0);
    check("mr_idle", busy, 0);

    // Prescaled instance sweep 2..5
    start3 = 1; mode = 0; lo = 2; hi = 5;
    cyc(); start3 = 0;
    check("ps_load", count3, 2);
    for (int c = 1; c <= 4 * EP; c++) begin
      cyc();
      check("ps_count", count3, (c / EP > 3) ? 5 : 2 + c / EP);
      check("ps_busy", busy3, c < 4 * EP);
      check("ps_done", done3, c == 4 * EP);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
